alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 tb/tb_alu_exec_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, default widths and the opcode type for the ALU execution unit.
// The optional signed-overflow output is enabled by defining ALU_OVF_EN.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 64;
    localparam int unsigned ALU_CNT_W  = 16;
    localparam int unsigned ALU_OP_W   = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'h0;
    localparam alu_op_t ALU_OR    = 4'h1;
    localparam alu_op_t ALU_ADD   = 4'h2;
    localparam alu_op_t ALU_SUB   = 4'h6;
    localparam alu_op_t ALU_PASSB = 4'h7;

    // True for the opcodes the datapath implements; everything else reports IllegalOp.
    function automatic logic op_is_legal(input alu_op_t op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: opcode -> {result, zero, illegal[, overflow]}.
// Signed overflow detection is present only when ALU_OVF_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result_c,
    output logic              zero_c,
    output logic              illegal_c
`ifdef ALU_OVF_EN
    ,
    output logic              overflow_c
`endif
);

    // Illegal opcodes fall through to a zero result.
    always_comb begin
        result_c  = '0;
        illegal_c = !op_is_legal(op);
        case (op)
            ALU_AND:   result_c = a & b;
            ALU_OR:    result_c = a | b;
            ALU_ADD:   result_c = a + b;
            ALU_SUB:   result_c = a - b;
            ALU_PASSB: result_c = b;
            default:   result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

`ifdef ALU_OVF_EN
    logic sign_a;
    logic sign_b;
    logic sign_r;

    assign sign_a = a[DATA_W-1];
    assign sign_b = b[DATA_W-1];
    assign sign_r = result_c[DATA_W-1];

    // Two's-complement overflow: result sign disagrees with what the operand signs imply.
    always_comb begin
        overflow_c = 1'b0;
        case (op)
            ALU_ADD: overflow_c = (sign_a == sign_b) && (sign_r != sign_a);
            ALU_SUB: overflow_c = (sign_a != sign_b) && (sign_r != sign_a);
            default: overflow_c = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage valid/ready ALU execution unit: S1 holds operands, S2 holds the registered result.
// Defining ALU_OVF_EN adds the registered Overflow output.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CNT_W  = ALU_CNT_W
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    input  alu_op_t           ALUCtrl,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] BusW,
    output logic              Zero,
    output logic              IllegalOp,
    output logic [CNT_W-1:0]  OpCount
`ifdef ALU_OVF_EN
    ,
    output logic              Overflow
`endif
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    alu_op_t           s1_op;

    logic              s1_adv;
    logic              s2_adv;
    logic              req_fire;
    logic              rsp_fire;

    logic [DATA_W-1:0] core_result;
    logic              core_zero;
    logic              core_illegal;
`ifdef ALU_OVF_EN
    logic              core_overflow;
`endif

    // A stage may load when it is empty or its contents leave on this edge.
    assign s2_adv   = !RspValid || RspReady;
    assign s1_adv   = !s1_valid || s2_adv;
    assign ReqReady = s1_adv && Reset_L;
    assign req_fire = ReqValid && ReqReady;
    assign rsp_fire = RspValid && RspReady;

    // S1: operand capture.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALU_AND;
        end else begin
            if (s1_adv) begin
                s1_valid <= req_fire;
            end
            if (req_fire) begin
                s1_a  <= BusA;
                s1_b  <= BusB;
                s1_op <= ALUCtrl;
            end
        end
    end

    alu_core #(
        .DATA_W     (DATA_W)
    ) u_core (
        .a          (s1_a),
        .b          (s1_b),
        .op         (s1_op),
        .result_c   (core_result),
        .zero_c     (core_zero),
        .illegal_c  (core_illegal)
`ifdef ALU_OVF_EN
        ,
        .overflow_c (core_overflow)
`endif
    );

    // S2: result register; payload only changes when a new result moves in.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            RspValid  <= 1'b0;
            BusW      <= '0;
            Zero      <= 1'b0;
            IllegalOp <= 1'b0;
        end else if (s2_adv) begin
            RspValid <= s1_valid;
            if (s1_valid) begin
                BusW      <= core_result;
                Zero      <= core_zero;
                IllegalOp <= core_illegal;
            end
        end
    end

`ifdef ALU_OVF_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            Overflow <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            Overflow <= core_overflow;
        end
    end
`endif

    // Completed-response counter, wraps naturally.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            OpCount <= '0;
        end else if (rsp_fire) begin
            OpCount <= OpCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, directed flow-control sequences, random traffic.
// Overflow checks are compiled in when ALU_OVF_EN is defined.
module tb_alu_exec_unit;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    logic          CLK = 1'b0;
    logic          Reset_L = 1'b1;
    logic          ReqValid = 1'b0;
    logic          ReqReady;
    logic [DW-1:0] BusA = '0;
    logic [DW-1:0] BusB = '0;
    logic [3:0]    ALUCtrl = '0;
    logic          RspValid;
    logic          RspReady = 1'b0;
    logic [DW-1:0] BusW;
    logic          Zero;
    logic          IllegalOp;
    logic [CW-1:0] OpCount;
`ifdef ALU_OVF_EN
    logic          Overflow;
`endif

    alu_exec_unit dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .BusA      (BusA),
        .BusB      (BusB),
        .ALUCtrl   (ALUCtrl),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .BusW      (BusW),
        .Zero      (Zero),
        .IllegalOp (IllegalOp),
        .OpCount   (OpCount)
`ifdef ALU_OVF_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] w;
        logic          z;
        logic          ill;
        logic          ovf;
    } exp_t;

    typedef struct {
        exp_t r;
        int   cyc;
    } obs_t;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        exp_t          e;
    } vec_t;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   mdl_count = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   req_cyc[$];
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_w = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; overflow judged by whether the exact signed sum fits.
    function automatic exp_t ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op);
        exp_t r;
        logic signed [DW:0] wide;
        logic signed [DW:0] smax;
        logic signed [DW:0] smin;
        smax = (65'sd1 <<< (DW - 1)) - 65'sd1;
        smin = -(65'sd1 <<< (DW - 1));
        wide = '0;
        r = '0;
        case (op)
            4'h0: r.w = a & b;
            4'h1: r.w = a | b;
            4'h2: begin
                wide  = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
                r.w   = a + b;
                r.ovf = (wide > smax) || (wide < smin);
            end
            4'h6: begin
                wide  = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
                r.w   = a - b;
                r.ovf = (wide > smax) || (wide < smin);
            end
            4'h7: r.w = b;
            default: r.ill = 1'b1;
        endcase
        r.z = (r.w == '0);
        return r;
    endfunction

    task automatic check_rsp(input string tag, input exp_t act, input exp_t exp);
        check({tag, "_busw"}, act.w, exp.w);
        check({tag, "_zero"}, 64'(act.z), 64'(exp.z));
        check({tag, "_illegal"}, 64'(act.ill), 64'(exp.ill));
`ifdef ALU_OVF_EN
        check({tag, "_ovf"}, 64'(act.ovf), 64'(exp.ovf));
`endif
    endtask

    // Monitor: inputs are stable at the falling edge, so this sees exactly what the next rising edge will.
    always @(negedge CLK) begin
        exp_t got;
        exp_t e;
        cyc++;
        if (!Reset_L) begin
            exp_q.delete();
            obs_q.delete();
            req_cyc.delete();
            mdl_count = 0;
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("hold_valid", 64'(RspValid), 64'(1));
                check("hold_busw", BusW, hold_w);
            end
            hold_valid = RspValid && !RspReady;
            hold_w     = BusW;
            if (RspValid && RspReady) begin
                got = '0;
                got.w = BusW;
                got.z = Zero;
                got.ill = IllegalOp;
`ifdef ALU_OVF_EN
                got.ovf = Overflow;
`endif
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_rsp("model", got, e);
                end
                obs_q.push_back('{r: got, cyc: cyc});
                mdl_count++;
            end
            if (ReqValid && ReqReady) begin
                exp_q.push_back(ref_alu(BusA, BusB, ALUCtrl));
                req_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int max_cyc, output bit acc);
        ALUCtrl  = op;
        BusA     = a;
        BusB     = b;
        ReqValid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge CLK);
            if (ReqReady) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0 && !RspValid) begin
                done = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        check(name, 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        Reset_L  = 1'b0;
        ReqValid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset_L = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] w, input logic z, input logic ill, input logic ovf);
        vec_t v;
        v.op = op;
        v.a = a;
        v.b = b;
        v.e.w = w;
        v.e.z = z;
        v.e.ill = ill;
        v.e.ovf = ovf;
        return v;
    endfunction

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        bit            acc;
        bit            acc_bp[3];
        logic [3:0]    op_list[5];
        logic [3:0]    rop;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        vecs[0]  = mk(4'h2, 64'h20, 64'h4500, 64'h4520, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(4'h0, 64'h53F15, 64'h17177, 64'h13115, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(4'h1, 64'h98967F, 64'hA98AC7, 64'hB99EFF, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(4'h6, 64'hFEDCBA, 64'hABCDEF, 64'h530ECB, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'h7, 64'h999, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(4'hF, 64'h123, 64'h456, 64'h0, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(4'h6, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(4'h6, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(4'h3, 64'hAAAA, 64'h5555, 64'h0, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(4'h7, 64'h0, 64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(4'h0, 64'hF0F0, 64'h0F0F, 64'h0, 1'b1, 1'b0, 1'b0);

        op_list[0] = 4'h0;
        op_list[1] = 4'h1;
        op_list[2] = 4'h2;
        op_list[3] = 4'h6;
        op_list[4] = 4'h7;

        // Reset values
        #3 Reset_L = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rspvalid", 64'(RspValid), 64'(0));
        check("rst_busw", BusW, 64'(0));
        check("rst_zero", 64'(Zero), 64'(0));
        check("rst_illegal", 64'(IllegalOp), 64'(0));
        check("rst_opcount", 64'(OpCount), 64'(0));
        check("rst_reqready", 64'(ReqReady), 64'(0));
`ifdef ALU_OVF_EN
        check("rst_ovf", 64'(Overflow), 64'(0));
`endif
        Reset_L = 1'b1;
        #1;
        check("rdy_after_rst", 64'(ReqReady), 64'(1));

        // Table vectors issued back-to-back with the consumer always ready
        @(posedge CLK);
        #1;
        RspReady = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, 4, acc);
            check("tbl_accept", 64'(acc), 64'(1));
        end
        ReqValid = 1'b0;
        wait_drain("tbl_drain");
        check("tbl_count", 64'(obs_q.size()), 64'(NV));
        for (int i = 0; i < NV && i < obs_q.size(); i++) begin
            check_rsp("tbl", obs_q[i].r, vecs[i].e);
            if (i > 0) check("tbl_b2b", 64'(obs_q[i].cyc - obs_q[i-1].cyc), 64'(1));
        end
        if (obs_q.size() > 0 && req_cyc.size() > 0)
            check("tbl_latency", 64'(obs_q[0].cyc - req_cyc[0]), 64'(2));
        check("tbl_opcount", 64'(OpCount), 64'(NV));
        obs_q.delete();
        req_cyc.delete();

        // Backpressure: only two fit, the head result holds, then everything drains in order
        RspReady = 1'b0;
        send(4'h2, 64'h10, 64'h1, 4, acc_bp[0]);
        send(4'h1, 64'hF0, 64'h0F, 4, acc_bp[1]);
        send(4'h6, 64'h1000, 64'h1, 4, acc_bp[2]);
        check("bp_acc0", 64'(acc_bp[0]), 64'(1));
        check("bp_acc1", 64'(acc_bp[1]), 64'(1));
        check("bp_acc2", 64'(acc_bp[2]), 64'(0));
        check("bp_reqready", 64'(ReqReady), 64'(0));
        check("bp_rspvalid", 64'(RspValid), 64'(1));
        check("bp_busw", BusW, 64'h11);
        repeat (3) @(posedge CLK);
        #1;
        check("bp_busw_held", BusW, 64'h11);
        RspReady = 1'b1;
        send(4'h6, 64'h1000, 64'h1, 6, acc);
        check("bp_acc2_late", 64'(acc), 64'(1));
        ReqValid = 1'b0;
        wait_drain("bp_drain");
        check("bp_count", 64'(obs_q.size()), 64'(3));
        if (obs_q.size() == 3) begin
            check("bp_rsp0", obs_q[0].r.w, 64'h11);
            check("bp_rsp1", obs_q[1].r.w, 64'hFF);
            check("bp_rsp2", obs_q[2].r.w, 64'hFFF);
        end
        check("bp_opcount", 64'(OpCount), 64'(NV + 3));
        obs_q.delete();

        // Reset with two requests in flight flushes everything
        RspReady = 1'b0;
        send(4'h2, 64'h5, 64'h6, 4, acc_bp[0]);
        send(4'h2, 64'h7, 64'h8, 4, acc_bp[1]);
        ReqValid = 1'b0;
        check("fl_acc", 64'(acc_bp[0] && acc_bp[1]), 64'(1));
        check("fl_pre_valid", 64'(RspValid), 64'(1));
        Reset_L = 1'b0;
        #1;
        check("fl_rspvalid", 64'(RspValid), 64'(0));
        check("fl_reqready", 64'(ReqReady), 64'(0));
        check("fl_opcount", 64'(OpCount), 64'(0));
        repeat (2) @(posedge CLK);
        #1;
        Reset_L  = 1'b1;
        RspReady = 1'b1;
        @(posedge CLK);
        #1;
        check("fl_rel_reqready", 64'(ReqReady), 64'(1));
        check("fl_rel_opcount", 64'(OpCount), 64'(0));
        repeat (5) @(posedge CLK);
        #1;
        check("fl_no_rsp", 64'(obs_q.size()), 64'(0));
        check("fl_rspvalid_low", 64'(RspValid), 64'(0));

        // Random traffic with random backpressure against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rop = (($urandom % 10) == 0) ? 4'($urandom) : op_list[$urandom_range(0, 4)];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 5))
                    0:       ra = '0;
                    1:       ra = '1;
                    2:       ra = 64'h8000_0000_0000_0000;
                    3:       ra = 64'h7FFF_FFFF_FFFF_FFFF;
                    4:       ra = 64'($urandom_range(0, 15));
                    default: ra = {$urandom, $urandom};
                endcase
                if (j == 0) rb = ra;
            end
            BusA     = rb;
            BusB     = ra;
            ALUCtrl  = rop;
            ReqValid = ($urandom % 4) != 0;
            RspReady = ($urandom % 3) != 0;
            @(posedge CLK);
            #1;
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        wait_drain("rnd_drain");
        check("rnd_opcount", 64'(OpCount), 64'(CW'(mdl_count)));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
